// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - memory-mapped multi-port GPIO controller with optional edge interrupts
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   din, addr, we    peripheral bus write data, word address, write enable
//   dout             registered read data (held while we=1)
//   gpio_in          pin inputs, port p at [p*DW +: DW]
//   gpio_out         OUT register of every port
//   gpio_oe          DIR register of every port (1 = drive)
//   irq              OR over all ports of (IS & IE)
//
// Build option: define GPIO_IRQ_EN to implement IE/IS/EDGE, edge detection,
// the startup mask counter and irq. Without it offsets 5-7 read 0 and irq is 0.
module gpio_bank #(
  parameter int          DW    = 16,
  parameter int          AW    = 13,
  parameter int          NPORT = 2,
  parameter logic [AW-1:0] BASE = 13'h000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       din,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  output logic [DW-1:0]       dout,
  input  logic [NPORT*DW-1:0] gpio_in,
  output logic [NPORT*DW-1:0] gpio_out,
  output logic [NPORT*DW-1:0] gpio_oe,
  output logic                irq
);

  logic [2:0]          port_sel;
  logic [2:0]          reg_sel;
  logic                hit;
  logic                wr_hit;
  logic [NPORT*DW-1:0] port_rd;
  logic [DW-1:0]       rd_data;

  assign port_sel = addr[5:3];
  assign reg_sel  = addr[2:0];
  // Extra leading zero keeps the compare valid when NPORT = 8.
  assign hit      = (addr[AW-1:6] == BASE[AW-1:6]) && ({1'b0, port_sel} < 4'(NPORT));
  assign wr_hit   = we && hit;

`ifdef GPIO_IRQ_EN
  logic [1:0]       start_cnt;
  logic             edge_ok;
  logic [NPORT-1:0] port_irq;

  // Suppresses spurious edges while the synchronisers fill after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 start_cnt <= 2'd0;
    else if (start_cnt != 2'd3) start_cnt <= start_cnt + 2'd1;
  end

  assign edge_ok = (start_cnt == 2'd3);
  assign irq     = |port_irq;
`else
  assign irq = 1'b0;
`endif

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic          sel;
    logic [DW-1:0] out_q, dir_q, s1_q, s2_q;
    logic [DW-1:0] rd;

    assign sel = wr_hit && (port_sel == 3'(p));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
        dir_q <= '0;
        s1_q  <= '0;
        s2_q  <= '0;
      end else begin
        s1_q <= gpio_in[p*DW +: DW];
        s2_q <= s1_q;
        if (sel) begin
          case (reg_sel)
            3'd1:    out_q <= din;
            3'd2:    dir_q <= din;
            3'd3:    out_q <= out_q | din;
            3'd4:    out_q <= out_q & ~din;
            default: ;
          endcase
        end
      end
    end

`ifdef GPIO_IRQ_EN
    logic [DW-1:0] ie_q, is_q, edge_q, h_q;
    logic [DW-1:0] edge_det;
    logic [DW-1:0] w1c;

    // Edge when the value changed and now matches the selected polarity.
    assign edge_det = (s2_q ^ h_q) & ~(s2_q ^ edge_q) & {DW{edge_ok}};
    assign w1c      = (sel && reg_sel == 3'd6) ? din : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ie_q   <= '0;
        is_q   <= '0;
        edge_q <= '0;
        h_q    <= '0;
      end else begin
        h_q  <= s2_q;
        // Set is applied after clear so a coincident edge is never lost.
        is_q <= (is_q & ~w1c) | edge_det;
        if (sel && reg_sel == 3'd5) ie_q   <= din;
        if (sel && reg_sel == 3'd7) edge_q <= din;
      end
    end

    assign port_irq[p] = |(is_q & ie_q);
`endif

    always_comb begin
      rd = '0;
      case (reg_sel)
        3'd0:    rd = s2_q;
        3'd1:    rd = out_q;
        3'd2:    rd = dir_q;
`ifdef GPIO_IRQ_EN
        3'd5:    rd = ie_q;
        3'd6:    rd = is_q;
        3'd7:    rd = edge_q;
`endif
        default: rd = '0;
      endcase
    end

    assign port_rd[p*DW +: DW]  = rd;
    assign gpio_out[p*DW +: DW] = out_q;
    assign gpio_oe[p*DW +: DW]  = dir_q;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (port_sel == 3'(i)) rd_data = port_rd[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dout <= '0;
    else if (!we) dout <= hit ? rd_data : '0;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - directed self-checking bench for gpio_bank
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [12:0] addr;
  logic        we;
  logic [15:0] dout;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(.DW(16), .AW(13), .NPORT(2), .BASE(13'h000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .addr     (addr),
    .we       (we),
    .dout     (dout),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rd(input logic [12:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    d = dout;
  endtask

  logic [15:0] r;

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    addr    = '0;
    we      = 1'b0;
    gpio_in = '1;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 16'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    check("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    rd(13'd6, r);  check("is_after_start", r, 16'h0);
    check("irq_after_start", irq, 1'b0);
    rd(13'd0, r);  check("in_p0", r, 16'hFFFF);
    rd(13'd8, r);  check("in_p1", r, 16'hFFFF);

    wr(13'd9, 16'h00F0);
    wr(13'd11, 16'h000F);
    wr(13'd12, 16'h0030);
    rd(13'd9, r);  check("out_p1", r, 16'h00CF);
    check("gpio_out_p1", gpio_out, 32'h00CF_0000);

    wr(13'd2, 16'h1234);
    check("oe_p0", gpio_oe, 32'h0000_1234);
    rd(13'd2, r);  check("dir_p0", r, 16'h1234);

    rd(13'd3, r);  check("set_reads0", r, 16'h0);
    rd(13'd12, r); check("clr_reads0", r, 16'h0);

    wr(13'd0, 16'h0000);
    rd(13'd0, r);  check("in_write_ignored", r, 16'hFFFF);

    // dout must hold while we=1 even though addr now points elsewhere.
    rd(13'd9, r);  check("pre_hold", r, 16'h00CF);
    addr = 13'd1; din = 16'h0005; we = 1'b1;
    @(negedge clk);
    check("dout_hold", dout, 16'h00CF);
    we = 1'b0;
    check("out_p0_write", gpio_out, 32'h00CF_0005);

    rd(13'd17, r); check("unmapped_port_rd", r, 16'h0);
    rd(13'd65, r); check("other_base_rd", r, 16'h0);
    wr(13'd17, 16'hFFFF);
    wr(13'd18, 16'hFFFF);
    wr(13'd65, 16'hFFFF);
    wr(13'd66, 16'hFFFF);
    check("unmapped_wr_out", gpio_out, 32'h00CF_0005);
    check("unmapped_wr_oe", gpio_oe, 32'h0000_1234);
    rd(13'd1, r);  check("out_p0_intact", r, 16'h0005);

`ifdef GPIO_IRQ_EN
    wr(13'd7, 16'hFFFF);
    @(negedge clk); gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd(13'd6, r);  check("fall_ignored_rising_mode", r, 16'h0);
    wr(13'd5, 16'h0001);
    check("irq_idle", irq, 1'b0);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(negedge clk); check("irq_k", irq, 1'b0);
    @(negedge clk); check("irq_k1", irq, 1'b0);
    @(negedge clk); check("irq_k2", irq, 1'b1);
    rd(13'd0, r);  check("in_bit0", r, 16'hFFFF);
    rd(13'd6, r);  check("is_bit0", r, 16'h0001);
    wr(13'd6, 16'h0001);
    check("irq_cleared", irq, 1'b0);
    rd(13'd6, r);  check("is_cleared", r, 16'h0);

    wr(13'd7, 16'hFFF7);
    @(negedge clk); gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd(13'd6, r);  check("is_bit3_fall", r, 16'h0008);
    check("irq_masked", irq, 1'b0);
    @(negedge clk); gpio_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    rd(13'd6, r);  check("rise_ignored_fall_mode", r, 16'h0008);
    // Second falling edge lands on the same edge as the W1C of bit 3.
    @(negedge clk); gpio_in[3] = 1'b0;
    @(negedge clk);
    @(negedge clk); addr = 13'd6; din = 16'h0008; we = 1'b1;
    @(negedge clk); we = 1'b0;
    rd(13'd6, r);  check("set_wins", r, 16'h0008);
    wr(13'd6, 16'h0008);
    rd(13'd6, r);  check("w1c_bit3", r, 16'h0);
`else
    wr(13'd5, 16'hFFFF);
    wr(13'd7, 16'hFFFF);
    gpio_in = '0;
    repeat (4) @(negedge clk);
    gpio_in = '1;
    repeat (4) @(negedge clk);
    check("irq_disabled", irq, 1'b0);
    rd(13'd5, r);  check("ie_reads0", r, 16'h0);
    rd(13'd7, r);  check("edge_reads0", r, 16'h0);
`endif

    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_out", gpio_out, 32'h0);
    check("midrst_oe", gpio_oe, 32'h0);
    check("midrst_dout", dout, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    rd(13'd9, r);  check("out_p1_after_rst", r, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
